// File: rtl/bram_rd_ctrl.sv
// rtl/bram_rd_ctrl.sv - two-client (word/row) read controller for a single 512-bit BRAM port
module bram_rd_ctrl #(
    parameter int RD_LATENCY = 2,
    parameter int WORD_AW    = 13,
    parameter int ROW_AW     = WORD_AW - 4
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [WORD_AW-1:0]  i_w_addr,
    input  logic                i_w_addr_ready,
    output logic                o_w_data_valid,
    output logic [31:0]         o_w_data,
    input  logic [ROW_AW-1:0]   i_r_addr,
    input  logic                i_r_addr_ready,
    output logic                o_r_data_valid,
    output logic [511:0]        o_r_data,
    output logic                o_bram_en,
    output logic [ROW_AW-1:0]   o_bram_addr,
    input  logic [511:0]        i_bram_dout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic GNT_R = 1'b0;
    localparam logic GNT_W = 1'b1;

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    logic [1:0]         state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               last_q, last_d;
    logic               abort_q, abort_d;
    logic [ROW_AW-1:0]  row_q, row_d;
    logic [3:0]         widx_q, widx_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               bram_en_q, bram_en_d;
    logic [ROW_AW-1:0]  bram_addr_q, bram_addr_d;
    logic               w_valid_q, w_valid_d;
    logic               r_valid_q, r_valid_d;
    logic [31:0]        w_data_q, w_data_d;
    logic [511:0]       r_data_q, r_data_d;

    logic               gnt_ready;
    logic               pick_w;

    assign gnt_ready = (gnt_q == GNT_W) ? i_w_addr_ready : i_r_addr_ready;
    // W wins when alone, or on a tie when R was served last
    assign pick_w    = i_w_addr_ready && (!i_r_addr_ready || (last_q == GNT_R));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        abort_d     = abort_q;
        row_d       = row_q;
        widx_d      = widx_q;
        cnt_d       = cnt_q;
        bram_en_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        w_valid_d   = w_valid_q;
        r_valid_d   = r_valid_q;
        w_data_d    = w_data_q;
        r_data_d    = r_data_q;

        case (state_q)
            ST_IDLE: begin
                if (i_w_addr_ready || i_r_addr_ready) begin
                    gnt_d   = pick_w;
                    row_d   = pick_w ? i_w_addr[WORD_AW-1:4] : i_r_addr;
                    widx_d  = i_w_addr[3:0];
                    abort_d = 1'b0;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                bram_en_d   = 1'b1;
                bram_addr_d = row_q;
                cnt_d       = LAT;
                if (!gnt_ready) begin
                    abort_d = 1'b1;
                end
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (!gnt_ready) begin
                    abort_d = 1'b1;
                end
                // The read is always allowed to finish so the BRAM pipeline drains
                if (cnt_q == 3'd0) begin
                    if (abort_q || !gnt_ready) begin
                        last_d  = gnt_q;
                        abort_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        if (gnt_q == GNT_W) begin
                            w_valid_d = 1'b1;
                            w_data_d  = i_bram_dout[{widx_q, 5'd0} +: 32];
                        end else begin
                            r_valid_d = 1'b1;
                            r_data_d  = i_bram_dout;
                        end
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            ST_HOLD: begin
                if (!gnt_ready) begin
                    w_valid_d = 1'b0;
                    r_valid_d = 1'b0;
                    w_data_d  = 32'd0;
                    r_data_d  = 512'd0;
                    last_d    = gnt_q;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_R;
            last_q      <= GNT_R;
            abort_q     <= 1'b0;
            row_q       <= '0;
            widx_q      <= 4'd0;
            cnt_q       <= 3'd0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            w_valid_q   <= 1'b0;
            r_valid_q   <= 1'b0;
            w_data_q    <= 32'd0;
            r_data_q    <= 512'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            abort_q     <= abort_d;
            row_q       <= row_d;
            widx_q      <= widx_d;
            cnt_q       <= cnt_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            w_valid_q   <= w_valid_d;
            r_valid_q   <= r_valid_d;
            w_data_q    <= w_data_d;
            r_data_q    <= r_data_d;
        end
    end

    assign o_bram_en      = bram_en_q;
    assign o_bram_addr    = bram_addr_q;
    assign o_w_data_valid = w_valid_q;
    assign o_w_data       = w_data_q;
    assign o_r_data_valid = r_valid_q;
    assign o_r_data       = r_data_q;

endmodule

// File: tb/tb_bram_rd_ctrl.sv
// tb/tb_bram_rd_ctrl.sv - directed vector bench for bram_rd_ctrl at read latencies 1, 2 and 4
module tb_bram_rd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    logic        rstn;
    logic [12:0] w_addr;
    logic        w_ready;
    logic [8:0]  r_addr;
    logic        r_ready;

    logic        wv   [3];
    logic [31:0] wd   [3];
    logic        rv   [3];
    logic [511:0] rd  [3];
    logic        en   [3];
    logic [8:0]  ba   [3];
    logic [511:0] dout [3];

    logic [511:0] mem [512];

    // index 0: latency 1, index 1: latency 2 (main), index 2: latency 4
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [511:0] pipe [4];

        always @(posedge clk) begin
            pipe[0] <= en[g] ? mem[ba[g]] : {16{32'hBAD00000 | cyc}};
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign dout[g] = pipe[LAT-1];

        bram_rd_ctrl #(.RD_LATENCY(LAT), .WORD_AW(13), .ROW_AW(9)) u_dut (
            .i_clk          (clk),
            .i_rstn         (rstn),
            .i_w_addr       (w_addr),
            .i_w_addr_ready (w_ready),
            .o_w_data_valid (wv[g]),
            .o_w_data       (wd[g]),
            .i_r_addr       (r_addr),
            .i_r_addr_ready (r_ready),
            .o_r_data_valid (rv[g]),
            .o_r_data       (rd[g]),
            .o_bram_en      (en[g]),
            .o_bram_addr    (ba[g]),
            .i_bram_dout    (dout[g])
        );
    end

    function automatic logic [31:0] word_val(input logic [8:0] r, input logic [3:0] w);
        return {7'h55, r, 4'h0, w, 8'hC3};
    endfunction

    function automatic logic [511:0] exp_row(input logic [8:0] r);
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[32*w +: 32] = word_val(r, 4'(w));
        return v;
    endfunction

    typedef struct {
        logic        rstn;
        logic        w_rdy;
        logic [12:0] w_a;
        logic        r_rdy;
        logic [8:0]  r_a;
        logic        en;
        logic [8:0]  ba;
        logic        wv;
        logic [31:0] wd;
        logic        rv;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; w_ready = 1'b0; r_ready = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    vec_t vt [9];

    initial begin
        int    first [3];
        int    lat, n_grant, n_en, bad_gap, both, nen_hold, nrv_hold;
        logic  got, saw, pv1, pv2, wprev, rprev;
        logic [31:0]  cap_w;
        logic [511:0] cap_r [3];
        string order;

        rstn = 1'b0; w_addr = '0; w_ready = 1'b0; r_addr = '0; r_ready = 1'b0;
        for (int r = 0; r < 512; r++) mem[r] = exp_row(9'(r));
        mem[9'h123][4*32 +: 32] = 32'hDEADBEEF;

        // single W read of 0x1234 on the latency-2 instance, cycle by cycle
        vt[0] = '{1'b0, 1'b0, 13'h0000, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 13'h1234, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h0, 1'b0};
        vt[2] = '{1'b1, 1'b1, 13'h1234, 1'b0, 9'h000, 1'b1, 9'h123, 1'b0, 32'h0, 1'b0};
        vt[3] = '{1'b1, 1'b1, 13'h1234, 1'b0, 9'h000, 1'b0, 9'h123, 1'b0, 32'h0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 13'h1234, 1'b0, 9'h000, 1'b0, 9'h123, 1'b0, 32'h0, 1'b0};
        vt[5] = '{1'b1, 1'b1, 13'h1234, 1'b0, 9'h000, 1'b0, 9'h123, 1'b1, 32'hDEADBEEF, 1'b0};
        vt[6] = '{1'b1, 1'b1, 13'h1234, 1'b0, 9'h000, 1'b0, 9'h123, 1'b1, 32'hDEADBEEF, 1'b0};
        vt[7] = '{1'b1, 1'b0, 13'h1234, 1'b0, 9'h000, 1'b0, 9'h123, 1'b0, 32'h0, 1'b0};
        vt[8] = '{1'b1, 1'b0, 13'h1234, 1'b0, 9'h000, 1'b0, 9'h123, 1'b0, 32'h0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            rstn = vt[i].rstn; w_ready = vt[i].w_rdy; w_addr = vt[i].w_a;
            r_ready = vt[i].r_rdy; r_addr = vt[i].r_a;
            step();
            chk($sformatf("v%0d.bram_en", i), en[1], vt[i].en);
            chk($sformatf("v%0d.bram_addr", i), ba[1], vt[i].ba);
            chk($sformatf("v%0d.w_valid", i), wv[1], vt[i].wv);
            chk($sformatf("v%0d.w_data", i), wd[1], vt[i].wd);
            chk($sformatf("v%0d.r_valid", i), rv[1], vt[i].rv);
            if (i == 0) chk("v0.r_data", rd[1], 512'd0);
        end

        // row 0x1FF read, valid timing across latencies 1/2/4
        do_reset();
        r_addr = 9'h1FF; r_ready = 1'b1;
        first = '{-1, -1, -1};
        saw = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            for (int g = 0; g < 3; g++) begin
                if (rv[g] && first[g] < 0) begin
                    first[g] = k;
                    cap_r[g] = rd[g];
                end
                if (wv[g]) saw = 1'b1;
            end
        end
        chk("row.lat1_first_valid", 512'(first[0]), 512'd3);
        chk("row.lat2_first_valid", 512'(first[1]), 512'd4);
        chk("row.lat4_first_valid", 512'(first[2]), 512'd6);
        chk("row.lat1_data", cap_r[0], exp_row(9'h1FF));
        chk("row.lat4_data", cap_r[2], exp_row(9'h1FF));
        chk("row.w_valid_seen", saw, 1'b0);
        r_ready = 1'b0;
        step(); step();
        chk("row.valid_released", {rv[0], rv[1], rv[2]}, 3'b000);

        // simultaneous requests alternate W, R, W, R
        do_reset();
        w_addr = 13'h0AB5; r_addr = 9'h010; w_ready = 1'b1; r_ready = 1'b1;
        order = ""; n_grant = 0; n_en = 0; bad_gap = 0; both = 0;
        pv1 = 1'b0; pv2 = 1'b0; wprev = 1'b0; rprev = 1'b0;
        for (int c = 0; c < 80 && n_grant < 4; c++) begin
            step();
            if (en[1]) begin
                n_en++;
                if (pv1 || pv2) bad_gap++;
            end
            if (wv[1] && rv[1]) both++;
            if (wv[1] && !wprev) begin
                order = {order, "W"}; n_grant++;
                chk("arb.w_data", wd[1], word_val(9'h0AB, 4'd5));
            end
            if (rv[1] && !rprev) begin
                order = {order, "R"}; n_grant++;
                chk("arb.r_data", rd[1], exp_row(9'h010));
            end
            pv2 = pv1; pv1 = wv[1] | rv[1];
            wprev = wv[1]; rprev = rv[1];
            if (wv[1]) w_ready = 1'b0; else if (!w_ready) w_ready = 1'b1;
            if (rv[1]) r_ready = 1'b0; else if (!r_ready) r_ready = 1'b1;
        end
        n_vec++;
        if (order != "WRWR") begin
            n_bad++;
            $display("FAIL arb.order: got %s expected WRWR", order);
        end
        chk("arb.en_pulses", 512'(n_en), 512'd4);
        chk("arb.no_idle_gap", 512'(bad_gap), 512'd0);
        chk("arb.both_valid", 512'(both), 512'd0);
        w_ready = 1'b0; r_ready = 1'b0;
        step(); step(); step();

        // W hold with moving address and toggling BRAM data, R pending
        w_addr = 13'h1234; w_ready = 1'b1; r_addr = 9'h055; r_ready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            if (wv[1]) got = 1'b1;
        end
        chk("hold.w_valid_reached", got, 1'b1);
        nen_hold = 0; nrv_hold = 0;
        for (int h = 0; h < 5; h++) begin
            w_addr = 13'($urandom);
            step();
            chk($sformatf("hold.w_data_c%0d", h), wd[1], 32'hDEADBEEF);
            if (en[1]) nen_hold++;
            if (rv[1]) nrv_hold++;
        end
        chk("hold.en_pulses", 512'(nen_hold), 512'd0);
        chk("hold.r_served_early", 512'(nrv_hold), 512'd0);
        w_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            if (rv[1]) got = 1'b1;
        end
        chk("hold.r_served_after", got, 1'b1);
        chk("hold.r_data", rd[1], exp_row(9'h055));
        r_ready = 1'b0;
        step(); step();

        // abort: R drops one cycle after the BRAM enable
        r_addr = 9'h077; r_ready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (en[1]) got = 1'b1;
        end
        chk("abort.en_seen", got, 1'b1);
        step();
        r_ready = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (rv[1]) saw = 1'b1;
        end
        chk("abort.r_valid_seen", saw, 1'b0);
        w_addr = 13'h1234; w_ready = 1'b1;
        lat = -1; cap_w = 32'd0;
        for (int k = 0; k < 16 && lat < 0; k++) begin
            step();
            if (wv[1]) begin lat = k; cap_w = wd[1]; end
        end
        chk("abort.next_w_latency", 512'(lat), 512'd4);
        chk("abort.next_w_data", cap_w, 32'hDEADBEEF);
        w_ready = 1'b0;
        step(); step();

        // reset in the middle of WAIT
        w_addr = 13'h1234; w_ready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (en[1]) got = 1'b1;
        end
        chk("rst.en_seen", got, 1'b1);
        step();
        rstn = 1'b0; w_ready = 1'b0;
        step();
        chk("rst.outputs_zero", {en[1], ba[1], wv[1], wd[1], rv[1]}, 44'd0);
        chk("rst.r_data_zero", rd[1], 512'd0);
        rstn = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (wv[1] || rv[1]) saw = 1'b1;
        end
        chk("rst.stale_valid", saw, 1'b0);
        w_addr = 13'h0AB5; w_ready = 1'b1;
        lat = -1; cap_w = 32'd0;
        for (int k = 0; k < 16 && lat < 0; k++) begin
            step();
            if (wv[1]) begin lat = k; cap_w = wd[1]; end
        end
        chk("rst.new_w_latency", 512'(lat), 512'd4);
        chk("rst.new_w_data", cap_w, word_val(9'h0AB, 4'd5));
        w_ready = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
